// File: rtl/approx_mult_pkg.sv
// Shared types and bit-cell functions for the approximate sequential multiplier.
// The approximate cell drops its carry-in; the exact cell is a plain full adder.
package approx_mult_pkg;

  localparam int DEF_N           = 8;
  localparam int DEF_APPROX_BITS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Returns {cout, sum}.
  function automatic logic [1:0] approx_cell(input logic x, input logic y);
    return {x & y, x | y};
  endfunction

  // Returns {cout, sum}.
  function automatic logic [1:0] exact_fa(input logic x, input logic y, input logic cin);
    return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

endpackage

// File: rtl/approx_seq_multiplier_hybrid_adder.sv
// Combinational N-bit hybrid adder: low APPROX_BITS positions use approximate
// cells, upper positions form an exact ripple chain ending in carry-out c.
module hybrid_adder
  import approx_mult_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic [N-1:0] h,
  input  logic [N-1:0] m,
  output logic [N-1:0] s,
  output logic         c
);

  logic cy;
  logic co;

  // Approximate cells ignore carry-in; only the top one's carry reaches the exact chain.
  always_comb begin
    s  = '0;
    cy = 1'b0;
    co = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i < APPROX_BITS) begin
        {co, s[i]} = approx_cell(h[i], m[i]);
        cy = co;
      end else begin
        {cy, s[i]} = exact_fa(h[i], m[i], cy);
      end
    end
    c = cy;
  end

endmodule

// File: rtl/approx_seq_multiplier.sv
// Shift-add multiplier: one partial product per clock through the hybrid adder.
// Handshake: a transfer happens on a cycle where valid and ready are both high at the clock edge.
module approx_seq_multiplier
  import approx_mult_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           gate_en,
  output logic           busy
);

  localparam int CW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   h_q, h_d;
  logic [N-1:0]   l_q, l_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  count_q, count_d;

  logic [N-1:0]   add_s;
  logic           add_c;

  hybrid_adder #(.N(N), .APPROX_BITS(APPROX_BITS)) u_adder (
    .h (h_q),
    .m (mcand_q),
    .s (add_s),
    .c (add_c)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign gate_en   = (state_q == S_RUN) && mplier_q[0];
  assign product   = {h_q, l_q};

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    l_d      = l_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = b;
          h_d      = '0;
          l_d      = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // {H,L} = {c,S,L} >> 1; with the add gated off, S is just H and c is 0.
        if (gate_en) begin
          h_d = {add_c, add_s[N-1:1]};
          l_d = {add_s[0], l_q[N-1:1]};
        end else begin
          h_d = {1'b0, h_q[N-1:1]};
          l_d = {h_q[0], l_q[N-1:1]};
        end
        mplier_d = {1'b0, mplier_q[N-1:1]};
        count_d  = count_q + 1'b1;
        if (count_q == CW'(N - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      h_q      <= '0;
      l_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      l_q      <= l_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_approx_seq_multiplier.sv
// Bench for approx_seq_multiplier: an exact (APPROX_BITS=0) and a hybrid
// (APPROX_BITS=4) instance share stimulus; expected products queue per instance.
module tb_approx_seq_multiplier;

  localparam int N = 8;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;

  logic         in_ready_x, out_valid_x, gate_en_x, busy_x;
  logic [W-1:0] product_x;
  logic         in_ready_a, out_valid_a, gate_en_a, busy_a;
  logic [W-1:0] product_a;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_x_q[$];
  logic [W-1:0] exp_a_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  approx_seq_multiplier #(.N(N), .APPROX_BITS(0)) dut_x (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x),
    .a(a), .b(b), .out_valid(out_valid_x), .out_ready(out_ready),
    .product(product_x), .gate_en(gate_en_x), .busy(busy_x)
  );

  approx_seq_multiplier #(.N(N), .APPROX_BITS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .a(a), .b(b), .out_valid(out_valid_a), .out_ready(out_ready),
    .product(product_a), .gate_en(gate_en_a), .busy(busy_a)
  );

  // Arithmetic model: hybrid add as (low OR field) + (exact upper sum with one carry-in).
  function automatic logic [W-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input int k);
    int h, l, s, low, high, cin, m;
    m = int'(ma);
    h = 0;
    l = 0;
    for (int it = 0; it < N; it++) begin
      if (mb[it]) begin
        low  = (h | m) & ((1 << k) - 1);
        cin  = (k > 0) ? ((h >> (k - 1)) & (m >> (k - 1)) & 1) : 0;
        high = (h >> k) + (m >> k) + cin;
        s    = (high << k) | low;
      end else begin
        s = h;
      end
      l = ((s & 1) << (N - 1)) | (l >> 1);
      h = s >> 1;
    end
    return W'((h << N) | l);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation to completion and records what the DUTs did; no judging here.
  task automatic do_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input int hold,
                       output logic [N-1:0] gate_trace, output int lat,
                       output logic [W-1:0] px, output logic [W-1:0] pa,
                       output logic ctrl_ok, output logic held_ok);
    ctrl_ok    = 1'b1;
    held_ok    = 1'b1;
    gate_trace = '0;
    lat        = -1;
    px         = 'x;
    pa         = 'x;
    a          = op_a;
    b          = op_b;
    in_valid   = 1'b1;
    out_ready  = (hold == 0);
    exp_x_q.push_back(model(op_a, op_b, 0));
    exp_a_q.push_back(model(op_a, op_b, 4));
    if (!(in_ready_x && in_ready_a)) ctrl_ok = 1'b0;
    step();
    in_valid = 1'b0;
    a = N'($urandom_range(0, 255));
    b = N'($urandom_range(0, 255));
    for (int cyc = 1; cyc <= N + 4; cyc++) begin
      if (out_valid_x) begin
        lat = cyc;
        break;
      end
      if (cyc <= N) gate_trace[cyc-1] = gate_en_x;
      if ({in_ready_x, busy_x, out_valid_x} !== 3'b010 ||
          {in_ready_a, busy_a, out_valid_a, gate_en_a} !== {in_ready_x, busy_x, out_valid_x, gate_en_x})
        ctrl_ok = 1'b0;
      step();
    end
    if (lat < 0) begin
      ctrl_ok   = 1'b0;
      out_ready = 1'b1;
      return;
    end
    px = product_x;
    pa = product_a;
    if ({in_ready_x, busy_x, gate_en_x, in_ready_a, busy_a, gate_en_a, out_valid_a} !== 7'b0000001)
      ctrl_ok = 1'b0;
    for (int hc = 0; hc < hold; hc++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(0, 255));
      step();
      if (!out_valid_x || !out_valid_a || product_x !== px || product_a !== pa ||
          in_ready_x || in_ready_a)
        held_ok = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    if ({in_ready_x, out_valid_x, busy_x, in_ready_a, out_valid_a, busy_a} !== 6'b100100)
      ctrl_ok = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) step();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready_x, out_valid_x, busy_x, gate_en_x} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags_x: got %b expected 1000", {in_ready_x, out_valid_x, busy_x, gate_en_x});
    end
    n_cmp++;
    if ({in_ready_a, out_valid_a, busy_a, gate_en_a} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags_a: got %b expected 1000", {in_ready_a, out_valid_a, busy_a, gate_en_a});
    end
    n_cmp++;
    if (product_x !== '0 || product_a !== '0) begin
      n_err++;
      $display("FAIL reset_product: got %0d/%0d expected 0", product_x, product_a);
    end
  endtask

  task automatic test_exact_13x11();
    logic [N-1:0] gt;
    int lat;
    logic [W-1:0] px, pa, ex, ea;
    logic cok, hok;
    do_op(8'd13, 8'd11, 0, gt, lat, px, pa, cok, hok);
    ex = exp_x_q.pop_front();
    ea = exp_a_q.pop_front();
    n_cmp++;
    if (px !== 16'd143) begin n_err++; $display("FAIL exact_13x11: got %0d expected 143", px); end
    n_cmp++;
    if (pa !== ea) begin n_err++; $display("FAIL approx_13x11: got %0d expected %0d", pa, ea); end
    n_cmp++;
    if (lat !== N + 1) begin n_err++; $display("FAIL latency_13x11: got %0d expected %0d", lat, N + 1); end
    n_cmp++;
    if (gt !== 8'b0000_1011) begin n_err++; $display("FAIL gate_13x11: got %b expected 00001011", gt); end
    n_cmp++;
    if (cok !== 1'b1) begin n_err++; $display("FAIL ctrl_13x11: got %b expected 1", cok); end
    if (ex !== 16'd143) begin n_cmp++; n_err++; $display("FAIL model_13x11: got %0d expected 143", ex); end
  endtask

  task automatic test_full_scale();
    logic [N-1:0] gt;
    int lat;
    logic [W-1:0] px, pa, ex, ea;
    logic cok, hok;
    do_op(8'd255, 8'd255, 0, gt, lat, px, pa, cok, hok);
    ex = exp_x_q.pop_front();
    ea = exp_a_q.pop_front();
    n_cmp++;
    if (px !== 16'd65025) begin n_err++; $display("FAIL exact_255x255: got %0d expected 65025", px); end
    n_cmp++;
    if (pa !== ea) begin n_err++; $display("FAIL approx_255x255: got %0d expected %0d", pa, ea); end
    n_cmp++;
    if (gt !== 8'hFF) begin n_err++; $display("FAIL gate_255x255: got %b expected 11111111", gt); end
    n_cmp++;
    if (cok !== 1'b1) begin n_err++; $display("FAIL ctrl_255x255: got %b expected 1", cok); end
    if (ex !== 16'd65025) begin n_cmp++; n_err++; $display("FAIL model_255x255: got %0d", ex); end
  endtask

  task automatic test_approx();
    logic [N-1:0] gt;
    int lat;
    logic [W-1:0] px, pa, ex, ea;
    logic cok, hok;
    do_op(8'h0F, 8'h03, 0, gt, lat, px, pa, cok, hok);
    ex = exp_x_q.pop_front();
    ea = exp_a_q.pop_front();
    n_cmp++;
    if (pa !== 16'd31) begin n_err++; $display("FAIL approx_0Fx03: got %0d expected 31", pa); end
    n_cmp++;
    if (px !== 16'd45) begin n_err++; $display("FAIL exact_0Fx03: got %0d expected 45", px); end
    do_op(8'd1, 8'd1, 0, gt, lat, px, pa, cok, hok);
    ex = exp_x_q.pop_front();
    ea = exp_a_q.pop_front();
    n_cmp++;
    if (pa !== 16'd1 || px !== 16'd1) begin
      n_err++;
      $display("FAIL one_x_one: got %0d/%0d expected 1/1", px, pa);
    end
    n_cmp++;
    if (cok !== 1'b1) begin n_err++; $display("FAIL ctrl_1x1: got %b expected 1", cok); end
  endtask

  task automatic test_zero();
    logic [N-1:0] ops_a [2];
    logic [N-1:0] gt;
    int lat;
    logic [W-1:0] px, pa, ex, ea;
    logic cok, hok;
    ops_a[0] = 8'd0;
    ops_a[1] = 8'd200;
    for (int i = 0; i < 2; i++) begin
      do_op(ops_a[i], 8'd0, 0, gt, lat, px, pa, cok, hok);
      ex = exp_x_q.pop_front();
      ea = exp_a_q.pop_front();
      n_cmp++;
      if (px !== '0 || pa !== '0) begin
        n_err++;
        $display("FAIL zero_product a=%0d: got %0d/%0d expected 0/0", ops_a[i], px, pa);
      end
      n_cmp++;
      if (gt !== '0) begin n_err++; $display("FAIL zero_gate a=%0d: got %b expected 0", ops_a[i], gt); end
      n_cmp++;
      if (lat !== N + 1) begin n_err++; $display("FAIL zero_latency a=%0d: got %0d expected %0d", ops_a[i], lat, N + 1); end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] gt, ra, rb;
    int lat;
    logic [W-1:0] px, pa, ex, ea;
    logic cok, hok;
    ra = N'($urandom_range(1, 255));
    rb = N'($urandom_range(1, 255));
    do_op(ra, rb, 5, gt, lat, px, pa, cok, hok);
    ex = exp_x_q.pop_front();
    ea = exp_a_q.pop_front();
    n_cmp++;
    if (hok !== 1'b1) begin n_err++; $display("FAIL backpressure_hold: got %b expected 1", hok); end
    n_cmp++;
    if (px !== ex || pa !== ea) begin
      n_err++;
      $display("FAIL backpressure_product %0dx%0d: got %0d/%0d expected %0d/%0d", ra, rb, px, pa, ex, ea);
    end
    n_cmp++;
    if (cok !== 1'b1) begin n_err++; $display("FAIL backpressure_ctrl: got %b expected 1", cok); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] gt, ra, rb;
    int lat;
    logic [W-1:0] px, pa, ex, ea;
    logic cok, hok;
    for (int i = 0; i < 6; i++) begin
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      do_op(ra, rb, 0, gt, lat, px, pa, cok, hok);
      ex = exp_x_q.pop_front();
      ea = exp_a_q.pop_front();
      n_cmp++;
      if (px !== ex || pa !== ea) begin
        n_err++;
        $display("FAIL b2b_product %0dx%0d: got %0d/%0d expected %0d/%0d", ra, rb, px, pa, ex, ea);
      end
      n_cmp++;
      if (gt !== rb || lat !== N + 1 || cok !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_timing %0dx%0d: got gate=%b lat=%0d ctrl=%b expected gate=%b lat=%0d ctrl=1",
                 ra, rb, gt, lat, cok, rb, N + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] gt;
    int lat;
    logic [W-1:0] px, pa, ex, ea;
    logic cok, hok;
    logic seen_valid;
    a = 8'd13;
    b = 8'd11;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready_x, out_valid_x, busy_x, in_ready_a, out_valid_a, busy_a} !== 6'b100100) begin
      n_err++;
      $display("FAIL midreset_flags: got %b expected 100100",
               {in_ready_x, out_valid_x, busy_x, in_ready_a, out_valid_a, busy_a});
    end
    n_cmp++;
    if (product_x !== '0 || product_a !== '0) begin
      n_err++;
      $display("FAIL midreset_product: got %0d/%0d expected 0", product_x, product_a);
    end
    seen_valid = 1'b0;
    repeat (N + 2) begin
      step();
      if (out_valid_x || out_valid_a) seen_valid = 1'b1;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin n_err++; $display("FAIL midreset_no_output: got %b expected 0", seen_valid); end
    do_op(8'd13, 8'd11, 0, gt, lat, px, pa, cok, hok);
    ex = exp_x_q.pop_front();
    ea = exp_a_q.pop_front();
    n_cmp++;
    if (px !== 16'd143) begin n_err++; $display("FAIL midreset_redo: got %0d expected 143", px); end
    n_cmp++;
    if (pa !== ea || cok !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_redo_approx: got %0d ctrl=%b expected %0d ctrl=1", pa, cok, ea);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_exact_13x11();
    test_full_scale();
    test_approx();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_x_q.size() != 0 || exp_a_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0", exp_x_q.size(), exp_a_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
